crc16_frame_arbiter: RTL and testbench

//   Shares one byte-wide CRC-16 engine between N_REQ byte-stream requesters.

---
 rtl/crc16_frame_arbiter.sv | 170 +++++++++++++++++
 tb/tb_crc16_frame_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_arbiter.sv
// Round-robin frame arbiter that shares one byte-wide CRC-16/BUYPASS engine and appends CRC[15:8], CRC[7:0].
// Optional per-requester frame counters are enabled by defining CRC16_ARB_FRAMECNT_EN.
module crc16_frame_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [8*N_REQ-1:0]       req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_last,
    input  logic                     out_ready,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy,
    output logic                     trunc_err
`ifdef CRC16_ARB_FRAMECNT_EN
    ,
    output logic [16*N_REQ-1:0]      frame_cnt
`endif
);

    localparam int GW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_LEN);

    typedef enum logic [1:0] {IDLE, DATA, CRC_HI, CRC_LO} state_t;

    state_t          state_q, state_d;
    logic [15:0]     crc_q, crc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic            trunc_q, trunc_d;
    logic [GW-1:0]   pick;
    logic            frame_done;

    // Poly 0x8005, MSB first, no reflection.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {b, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[15] ? ((c << 1) ^ 16'h8005) : (c << 1);
        end
        return c;
    endfunction

    function automatic logic [GW-1:0] arbitrate(input logic [N_REQ-1:0] valid, input logic [GW-1:0] ptr);
        logic [GW-1:0] sel;
        logic          found;
        int            idx;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (!found && valid[idx]) begin
                found = 1'b1;
                sel   = GW'(idx);
            end
        end
        return sel;
    endfunction

    assign pick = arbitrate(req_valid, rr_q);

    // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        rr_d       = rr_q;
        trunc_d    = 1'b0;
        frame_done = 1'b0;
        req_ready  = '0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_valid) begin
                    grant_d = pick;
                    crc_d   = 16'h0000;
                    cnt_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                req_ready[grant_q] = out_ready;
                out_valid          = req_valid[grant_q];
                out_data           = req_data[8*grant_q +: 8];
                if (req_valid[grant_q] && out_ready) begin
                    crc_d = crc16_byte(crc_q, req_data[8*grant_q +: 8]);
                    cnt_d = cnt_q + 1'b1;
                    if (req_last[grant_q]) begin
                        state_d = CRC_HI;
                    end else if (cnt_q == CW'(MAX_LEN - 1)) begin
                        // Cut here; the rest of the stream competes again as a new frame.
                        state_d = CRC_HI;
                        trunc_d = 1'b1;
                    end
                end
            end
            CRC_HI: begin
                out_valid = 1'b1;
                out_data  = crc_q[15:8];
                if (out_ready) state_d = CRC_LO;
            end
            CRC_LO: begin
                out_valid = 1'b1;
                out_data  = crc_q[7:0];
                out_last  = 1'b1;
                if (out_ready) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                    rr_d       = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            crc_q   <= 16'h0000;
            cnt_q   <= '0;
            grant_q <= '0;
            rr_q    <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            trunc_q <= trunc_d;
        end
    end

    assign grant_id  = grant_q;
    assign busy      = (state_q != IDLE);
    assign trunc_err = trunc_q;

`ifdef CRC16_ARB_FRAMECNT_EN
    logic [15:0] fcnt_q [N_REQ];
    logic [15:0] fcnt_d [N_REQ];

    always_comb begin
        for (int i = 0; i < N_REQ; i++) fcnt_d[i] = fcnt_q[i];
        if (frame_done) fcnt_d[grant_q] = fcnt_q[grant_q] + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) fcnt_q[i] <= 16'h0000;
        end else begin
            for (int i = 0; i < N_REQ; i++) fcnt_q[i] <= fcnt_d[i];
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) frame_cnt[16*i +: 16] = fcnt_q[i];
    end
`endif

endmodule

// File: tb/tb_crc16_frame_arbiter.sv
// Self-checking bench for crc16_frame_arbiter: a cycle table on a MAX_LEN=4 instance for truncation,
// plus queue-driven frame streams on the default instance for CRC, round-robin, stalls and reset.
module tb_crc16_frame_arbiter;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           out_valid, out_last, out_ready, busy, trunc_err;
    logic [7:0]     out_data;
    logic [1:0]     grant_id;

    logic [1:0]  t_req_valid, t_req_last, t_req_ready;
    logic [15:0] t_req_data;
    logic        t_out_valid, t_out_last, t_out_ready, t_busy, t_trunc_err;
    logic [7:0]  t_out_data;
    logic [0:0]  t_grant_id;

`ifdef CRC16_ARB_FRAMECNT_EN
    logic [16*N-1:0] frame_cnt;
    logic [31:0]     t_frame_cnt;
`endif

    crc16_frame_arbiter #(.N_REQ(N), .MAX_LEN(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .grant_id(grant_id), .busy(busy), .trunc_err(trunc_err)
`ifdef CRC16_ARB_FRAMECNT_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    crc16_frame_arbiter #(.N_REQ(2), .MAX_LEN(4)) dut_t (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_req_valid), .req_data(t_req_data), .req_last(t_req_last), .req_ready(t_req_ready),
        .out_valid(t_out_valid), .out_data(t_out_data), .out_last(t_out_last), .out_ready(t_out_ready),
        .grant_id(t_grant_id), .busy(t_busy), .trunc_err(t_trunc_err)
`ifdef CRC16_ARB_FRAMECNT_EN
        , .frame_cnt(t_frame_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle vectors for the MAX_LEN=4 instance, requester 0 only.
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       ordy;
        logic       e_ov;
        logic [7:0] e_od;
        logic       e_ol;
        logic       e_rdy;
        logic       e_busy;
        logic       e_trunc;
    } tvec_t;

    tvec_t tv [16];

    logic [8:0]  src_q [N][$];  // {last, data}
    logic [10:0] exp_q [$];     // {grant, last, data}

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_valid[i]       = 1'b1;
                req_data[8*i +: 8] = src_q[i][0][7:0];
                req_last[i]        = src_q[i][0][8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[8*i +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic add_str(input int r, input string s, input logic [15:0] crc);
        for (int i = 0; i < s.len(); i++) begin
            src_q[r].push_back({(i == s.len() - 1), s[i]});
            exp_q.push_back({2'(r), 1'b0, s[i]});
        end
        exp_q.push_back({2'(r), 1'b0, crc[15:8]});
        exp_q.push_back({2'(r), 1'b1, crc[7:0]});
    endtask

    task automatic add2(input int r, input int len, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [15:0] crc);
        logic [7:0] b [2];
        b[0] = b0;
        b[1] = b1;
        for (int i = 0; i < len; i++) begin
            src_q[r].push_back({(i == len - 1), b[i]});
            exp_q.push_back({2'(r), 1'b0, b[i]});
        end
        exp_q.push_back({2'(r), 1'b0, crc[15:8]});
        exp_q.push_back({2'(r), 1'b1, crc[7:0]});
    endtask

    function automatic bit sources_empty();
        for (int i = 0; i < N; i++) if (src_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Entered just after a rising edge; leaves just after a rising edge.
    task automatic run(input int max_cycles, input bit rnd, input int stop_after);
        int         cyc;
        int         nbytes;
        bit         stall_prev;
        bit         done;
        logic [7:0] prev_data;
        logic [N-1:0] fired;
        logic [10:0] e;
        cyc = 0; nbytes = 0; stall_prev = 1'b0; done = 1'b0; prev_data = 8'h00;
        drive();
        while (cyc < max_cycles) begin
            if (stop_after == 0 && exp_q.size() == 0 && sources_empty()) begin done = 1'b1; break; end
            if (stop_after != 0 && nbytes >= stop_after) begin done = 1'b1; break; end
            @(negedge clk);
            check("ready_onehot", 32'($countones(req_ready) <= 1), 32'd1);
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_byte: got 0x%0h with no byte expected", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e[7:0]));
                    check("out_last", 32'(out_last), 32'(e[8]));
                    check("grant_id", 32'(grant_id), 32'(e[10:9]));
                end
                nbytes++;
            end
            stall_prev = out_valid && !out_ready;
            prev_data  = out_data;
            fired      = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) if (fired[i]) void'(src_q[i].pop_front());
            drive();
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cyc++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout: %0d expected bytes still pending", exp_q.size());
        end
        out_ready = 1'b1;
    endtask

    task automatic check_main_zero(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_grant_id"},  32'(grant_id),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
        check({tag, "_trunc_err"}, 32'(trunc_err), 32'd0);
    endtask

    initial begin
        //            v   d      l  rdy  ov  od     ol rdy busy trunc
        tv[0]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[2]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[3]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[4]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[5]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[6]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[7]  = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1};
        tv[8]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[9]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h05, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[10] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tv[11] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[12] = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tv[13] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h86, 1'b0, 1'b0, 1'b1, 1'b0};
        tv[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 1'b0};
        tv[15] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
        t_req_valid = '0; t_req_data = '0; t_req_last = '0; t_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        check_main_zero("reset");
        check("reset_t_busy", 32'(t_busy), 32'd0);
        check("reset_t_out_valid", 32'(t_out_valid), 32'd0);
`ifdef CRC16_ARB_FRAMECNT_EN
        check("reset_frame_cnt", frame_cnt[31:0], 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Truncation at MAX_LEN=4: 00 00 00 01 | 01 00(last), with stalls in DATA and CRC_HI.
        for (int r = 0; r < 16; r++) begin
            t_req_valid = {1'b0, tv[r].v};
            t_req_data  = {8'h00, tv[r].d};
            t_req_last  = {1'b0, tv[r].l};
            t_out_ready = tv[r].ordy;
            @(negedge clk);
            check($sformatf("t%0d_out_valid", r), 32'(t_out_valid), 32'(tv[r].e_ov));
            if (tv[r].e_ov) begin
                check($sformatf("t%0d_out_data", r), 32'(t_out_data), 32'(tv[r].e_od));
                check($sformatf("t%0d_out_last", r), 32'(t_out_last), 32'(tv[r].e_ol));
            end
            check($sformatf("t%0d_req_ready", r), 32'(t_req_ready), {31'd0, tv[r].e_rdy});
            check($sformatf("t%0d_busy", r), 32'(t_busy), 32'(tv[r].e_busy));
            check($sformatf("t%0d_trunc_err", r), 32'(t_trunc_err), 32'(tv[r].e_trunc));
            check($sformatf("t%0d_grant_id", r), 32'(t_grant_id), 32'd0);
            @(posedge clk);
            #1;
        end
`ifdef CRC16_ARB_FRAMECNT_EN
        check("t_frame_cnt", t_frame_cnt, 32'h0000_0002);
`endif

        // Round robin from pointer 0: grants 0,1,2,3,0 with whole frames.
        add2(0, 2, 8'h00, 8'h01, 16'h8005);
        add2(1, 2, 8'h01, 8'h00, 16'h8603);
        add2(2, 2, 8'h00, 8'h80, 16'h8303);
        add2(3, 2, 8'h00, 8'h00, 16'h0000);
        add2(0, 2, 8'h00, 8'h00, 16'h0000);
        run(200, 1'b0, 0);

        // Check string at full rate.
        add_str(0, "123456789", 16'hFEE8);
        run(100, 1'b0, 0);

        // Single-byte frames; pointer is 1 so requester 1 goes first, then alternates.
        add2(1, 1, 8'h80, 8'h00, 16'h8303);
        add2(0, 1, 8'h01, 8'h00, 16'h8005);
        add2(1, 2, 8'h01, 8'h00, 16'h8603);
        add2(0, 1, 8'h00, 8'h00, 16'h0000);
        run(200, 1'b0, 0);

        // Check string under random backpressure.
        add_str(0, "123456789", 16'hFEE8);
        run(600, 1'b1, 0);

        // Reset after three payload bytes, then a clean frame.
        add_str(0, "123456789", 16'hFEE8);
        run(100, 1'b0, 3);
        rst_n = 1'b0;
        #1;
        check_main_zero("midrst");
        @(posedge clk);
        #1;
        check_main_zero("midrst_edge");
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        drive();
`ifdef CRC16_ARB_FRAMECNT_EN
        check("midrst_frame_cnt", frame_cnt[31:0], 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        add_str(0, "123456789", 16'hFEE8);
        run(100, 1'b0, 0);
`ifdef CRC16_ARB_FRAMECNT_EN
        check("final_frame_cnt0", 32'(frame_cnt[15:0]), 32'd1);
        check("final_frame_cnt1", 32'(frame_cnt[31:16]), 32'd0);
`endif
        check("final_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
